// File: rtl/tnn_feature_packer.sv
// ----------------------------------------------------------------------------
// tnn_feature_packer
//
// Producer-side front end for the 2-bit-per-feature TNN classifiers. Raw
// feature beats arrive one at a time on a valid/ready stream. Each beat is
// quantized to a 2-bit code with three fixed thresholds, and the codes are
// assembled into a packed vector. A complete sample is presented to an
// external combinational classifier on feat_vec. The class bit that comes
// back on cls_in is registered and handed off on an output valid/ready
// stream.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   s_valid    in   raw feature beat valid
//   s_ready    out  packer can accept a beat (COLLECT state only)
//   s_data     in   raw unsigned feature value [RAW_WIDTH]
//   s_last     in   final feature of a sample
//   feat_vec   out  packed codes, feature k at [2k+1:2k] [2*NUM_FEATURES]
//   cls_in     in   classifier result, combinational from feat_vec
//   m_valid    out  class result valid
//   m_ready    in   downstream accepts result
//   m_class    out  registered class bit
//   frame_err  out  one-cycle pulse on a malformed sample
//   sample_cnt out  results handed off, wraps [CNT_WIDTH]
// ----------------------------------------------------------------------------
module tnn_feature_packer #(
    parameter int NUM_FEATURES = 7,
    parameter int RAW_WIDTH    = 8,
    parameter int THR1         = 64,
    parameter int THR2         = 128,
    parameter int THR3         = 192,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [RAW_WIDTH-1:0]      s_data,
    input  logic                      s_last,
    output logic [2*NUM_FEATURES-1:0] feat_vec,
    input  logic                      cls_in,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_class,
    output logic                      frame_err,
    output logic [CNT_WIDTH-1:0]      sample_cnt
);

    localparam int VEC_W = 2 * NUM_FEATURES;
    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic [RAW_WIDTH-1:0] L_THR1   = RAW_WIDTH'(THR1);
    localparam logic [RAW_WIDTH-1:0] L_THR2   = RAW_WIDTH'(THR2);
    localparam logic [RAW_WIDTH-1:0] L_THR3   = RAW_WIDTH'(THR3);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EVAL    = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [IDX_W-1:0]     r_idx, w_idx_next;
    logic [VEC_W-1:0]     r_asm, w_asm_next, w_asm_beat;
    logic [VEC_W-1:0]     r_feat, w_feat_next;
    logic                 r_m_valid, w_m_valid_next;
    logic                 r_m_class, w_m_class_next;
    logic                 r_frame_err, w_frame_err_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                 w_accept;
    logic [1:0]           w_code;

    // Unsigned threshold compare; thresholds are strictly increasing.
    function automatic logic [1:0] f_quantize(input logic [RAW_WIDTH-1:0] raw);
        if (raw < L_THR1)      return 2'd0;
        else if (raw < L_THR2) return 2'd1;
        else if (raw < L_THR3) return 2'd2;
        else                   return 2'd3;
    endfunction

    assign s_ready = (r_state == ST_COLLECT);

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_asm_next       = r_asm;
        w_feat_next      = r_feat;
        w_m_valid_next   = r_m_valid;
        w_m_class_next   = r_m_class;
        w_frame_err_next = 1'b0;
        w_cnt_next       = r_cnt;

        w_code   = f_quantize(s_data);
        w_accept = s_valid && (r_state == ST_COLLECT);

        // Assembly contents including the current beat, so the final beat
        // reaches feat_vec in the same cycle it is accepted.
        w_asm_beat = r_asm;
        w_asm_beat[int'(r_idx) * 2 +: 2] = w_code;

        case (r_state)
            ST_COLLECT: begin
                if (w_accept) begin
                    if (s_last && (r_idx == LAST_IDX)) begin
                        w_feat_next  = w_asm_beat;
                        w_asm_next   = '0;
                        w_idx_next   = '0;
                        w_state_next = ST_EVAL;
                    end else if (s_last || (r_idx == LAST_IDX)) begin
                        // Early s_last or missing s_last: drop the partial
                        // sample and realign so the next beat is feature 0.
                        w_frame_err_next = 1'b1;
                        w_asm_next       = '0;
                        w_idx_next       = '0;
                    end else begin
                        w_asm_next = w_asm_beat;
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                w_m_class_next = cls_in;
                w_m_valid_next = 1'b1;
                w_state_next   = ST_OUT;
            end
            ST_OUT: begin
                if (m_ready) begin
                    w_m_valid_next = 1'b0;
                    w_cnt_next     = r_cnt + 1'b1;
                    w_state_next   = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_idx       <= '0;
            r_asm       <= '0;
            r_feat      <= '0;
            r_m_valid   <= 1'b0;
            r_m_class   <= 1'b0;
            r_frame_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_asm       <= w_asm_next;
            r_feat      <= w_feat_next;
            r_m_valid   <= w_m_valid_next;
            r_m_class   <= w_m_class_next;
            r_frame_err <= w_frame_err_next;
            r_cnt       <= w_cnt_next;
        end
    end

    assign feat_vec   = r_feat;
    assign m_valid    = r_m_valid;
    assign m_class    = r_m_class;
    assign frame_err  = r_frame_err;
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_tnn_feature_packer.sv
// ----------------------------------------------------------------------------
// Testbench for tnn_feature_packer. A driver issues directed and randomized
// beats and updates a sample-level reference model; a monitor on the falling
// edge pops expected results whenever a result handshake happens.
// ----------------------------------------------------------------------------
module tb_tnn_feature_packer;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [13:0] feat_vec;
    logic        cls_in;
    logic        m_valid;
    logic        m_ready;
    logic        m_class;
    logic        frame_err;
    logic [15:0] sample_cnt;

    tnn_feature_packer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .feat_vec   (feat_vec),
        .cls_in     (cls_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_class    (m_class),
        .frame_err  (frame_err),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in classifier: class 1 when the seven codes sum to 10 or more.
    function automatic logic classify(input logic [13:0] v);
        int s;
        s = 0;
        for (int k = 0; k < 7; k++) s += int'(v[2*k +: 2]);
        return (s >= 10);
    endfunction

    assign cls_in = classify(feat_vec);

    typedef struct {
        logic [13:0] feat;
        logic        cls;
    } exp_t;

    exp_t        exp_q[$];
    int          cur[$];
    logic [13:0] exp_feat;
    logic [15:0] exp_cnt;
    int          exp_ferr;
    int          obs_ferr;
    int          n_tests;
    int          n_fail;
    bit          rand_mode;
    logic [7:0]  sq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model at sample level: code = raw/64, seven codes per sample.
    task automatic model_accept(input logic [7:0] d, input logic last);
        logic [13:0] f;
        cur.push_back(int'(d) / 64);
        if (last) begin
            if (cur.size() == 7) begin
                f = '0;
                for (int k = 0; k < 7; k++) f = f | (14'(cur[k]) << (2*k));
                exp_feat = f;
                exp_q.push_back('{feat: f, cls: classify(f)});
            end else begin
                exp_ferr++;
            end
            cur.delete();
        end else if (cur.size() == 7) begin
            exp_ferr++;
            cur.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int guard;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        guard   = 0;
        while (!s_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            check("accept_timeout", 32'd1, 32'd0);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d, last);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (rand_mode) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_seq(input int last_at);
        for (int i = 0; i < sq.size(); i++) send_beat(sq[i], (i == last_at));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        exp_q.delete();
        cur.delete();
        exp_feat = '0;
        check("rst_feat_vec", feat_vec, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_class", m_class, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_s_ready", s_ready, 1);
        rst = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_cnt = '0;
        end else begin
            check("sample_cnt", sample_cnt, exp_cnt);
            check("feat_vec_hold", feat_vec, exp_feat);
            if (frame_err) obs_ferr++;
            if (m_valid && s_ready) check("backpressure", s_ready, 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_class", m_class, e.cls);
                    check("result_feat", feat_vec, e.feat);
                end
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial begin
        int guard;
        logic [7:0] edges[8];
        logic [7:0] hold_cls;
        n_tests   = 0;
        n_fail    = 0;
        exp_ferr  = 0;
        obs_ferr  = 0;
        exp_feat  = '0;
        exp_cnt   = '0;
        rand_mode = 1'b0;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        m_ready   = 1'b1;
        edges     = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd0, 8'd255};
        tick();
        do_reset();

        // Basic sample and latency
        sq = '{8'd10, 8'd70, 8'd130, 8'd200, 8'd63, 8'd64, 8'd255};
        send_seq(6);
        check("t1_feat", feat_vec, 32'h34E4);
        check("t1_mvalid_eval", m_valid, 0);
        check("t1_sready_eval", s_ready, 0);
        tick();
        check("t1_mvalid", m_valid, 1);
        check("t1_mclass", m_class, 1);
        tick();
        check("t1_mvalid_done", m_valid, 0);
        check("t1_cnt", sample_cnt, 1);
        check("t1_sready", s_ready, 1);

        // Output backpressure
        do_reset();
        m_ready = 1'b0;
        send_seq(6);
        tick();
        hold_cls = {7'd0, m_class};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_mvalid_hold", m_valid, 1);
            check("t2_mclass_hold", m_class, hold_cls);
            check("t2_sready_low", s_ready, 0);
            check("t2_cnt_hold", sample_cnt, 0);
        end
        m_ready = 1'b1;
        tick();
        check("t2_cnt", sample_cnt, 1);
        check("t2_mvalid_done", m_valid, 0);

        // Early s_last
        sq = '{8'd1, 8'd2, 8'd3};
        send_seq(2);
        check("t3_ferr", frame_err, 1);
        check("t3_feat_kept", feat_vec, 32'h34E4);
        check("t3_no_mvalid", m_valid, 0);
        tick();
        check("t3_ferr_pulse", frame_err, 0);
        sq = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        send_seq(6);
        check("t3_feat_full", feat_vec, 32'h3FFF);
        tick();
        tick();

        // Missing s_last, then threshold edges starting at feature 0
        sq = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        send_seq(-1);
        check("t4_ferr", frame_err, 1);
        check("t4_feat_kept", feat_vec, 32'h3FFF);
        sq = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd0};
        send_seq(6);
        check("t5_feat_edges", feat_vec, 32'h0E94);
        tick();
        check("t5_mclass", m_class, 0);
        tick();

        // Reset in EVAL and during a partial sample
        sq = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0, 8'd64, 8'd128};
        send_seq(6);
        do_reset();
        sq = '{8'd90, 8'd90, 8'd90, 8'd90};
        send_seq(-1);
        do_reset();
        sq = '{8'd10, 8'd70, 8'd130, 8'd200, 8'd63, 8'd64, 8'd255};
        send_seq(6);
        check("t6_feat_after_rst", feat_vec, 32'h34E4);
        tick();
        tick();
        check("t6_cnt", sample_cnt, 1);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int kind;
            int len;
            int last_at;
            kind    = $urandom_range(0, 5);
            len     = 7;
            last_at = 6;
            if (kind == 0) begin
                len     = $urandom_range(1, 6);
                last_at = len - 1;
            end else if (kind == 1) begin
                last_at = -1;
            end
            sq.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0) sq.push_back(edges[$urandom_range(0, 7)]);
                else sq.push_back(8'($urandom));
            end
            send_seq(last_at);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        // Drain
        rand_mode = 1'b0;
        m_ready   = 1'b1;
        guard     = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_timeout", (guard >= 100), 0);
        tick();
        tick();
        check("frame_err_count", obs_ferr, exp_ferr);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tnn_feature_packer.md
Name: tnn_feature_packer

Overview:
- Producer-side front end for the 2-bit-per-feature approximate TNN classifiers (7 features, 1-bit class output).
- Accepts raw feature samples one beat at a time on a valid/ready stream and quantizes each to 2 bits with fixed thresholds.
- Assembles the 14-bit packed feature vector, presents it to the combinational classifier, registers the class bit and returns it on an output valid/ready stream.

Parameters:
- NUM_FEATURES, 7, features per sample; the packed vector is 2*NUM_FEATURES bits.
- RAW_WIDTH, 8, width of one raw feature beat.
- THR1, 64, lower quantization threshold.
- THR2, 128, middle quantization threshold.
- THR3, 192, upper quantization threshold (THR1 < THR2 < THR3 required).
- CNT_WIDTH, 16, width of the completed-sample counter.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  raw feature beat valid.
- s_ready  output  1  packer can accept a beat.
- s_data  input  RAW_WIDTH  raw feature value, unsigned.
- s_last  input  1  marks the final feature of a sample.
- feat_vec  output  2*NUM_FEATURES  packed codes to classifier; feature k at bits [2k+1:2k] (k=0 maps to classifier input_a, k=6 to input_g).
- cls_in  input  1  classifier output bit, combinational from feat_vec.
- m_valid  output  1  class result valid.
- m_ready  input  1  downstream accepts result.
- m_class  output  1  registered class bit.
- frame_err  output  1  one-cycle pulse on sample framing error.
- sample_cnt  output  CNT_WIDTH  count of results handed off (m_valid&&m_ready).

Behaviour:
- Reset values: state=COLLECT, idx=0, assembly register=0, feat_vec=0, m_valid=0, m_class=0, frame_err=0, sample_cnt=0. Reset mid-sample or mid-handoff discards everything with no output.
- Quantization, unsigned compare: code=0 if raw<THR1; 1 if raw<THR2; 2 if raw<THR3; else 3. Example: 63→0, 64→1, 255→3.
- Beat accepted when s_valid&&s_ready. s_ready=1 only in COLLECT.
- COLLECT:
  - Each accepted beat writes its code into assembly slot idx. feat_vec is unchanged during collection.
  - Accept with idx==NUM_FEATURES-1 and s_last=1: copy assembly (including this beat) to feat_vec, idx←0, go EVAL.
  - Accept with s_last=1 and idx<NUM_FEATURES-1, or with idx==NUM_FEATURES-1 and s_last=0: frame_err=1 next cycle, discard partial sample, idx←0, stay COLLECT. feat_vec and m_class unchanged.
  - Otherwise idx←idx+1.
- EVAL (1 cycle): m_class←cls_in, m_valid←1, go OUT.
- OUT:
  - m_valid held high and m_class held stable until m_ready.
  - On m_valid&&m_ready: m_valid←0, sample_cnt←sample_cnt+1 (wraps modulo 2^CNT_WIDTH), go COLLECT.
  - s_ready=0 throughout EVAL and OUT (backpressure).
- Latency: final beat accepted in cycle t → feat_vec updated at t+1 → m_valid high at t+2. With m_ready held high, the next beat is accepted no earlier than t+3. Sustained throughput is NUM_FEATURES+2 cycles per sample.
- feat_vec holds the last completed sample until the next sample completes. frame_err never asserts outside COLLECT.

Test Plan:
- Reset, then feed beats 10,70,130,200,63,64,255 (s_last on the 7th), m_ready=1 → feat_vec=0x34E4 one cycle after the last beat; m_valid one cycle later with m_class equal to the cls_in value during EVAL; sample_cnt=1.
- Same sample with m_ready=0 for 5 cycles → m_valid and m_class stable, s_ready=0, sample_cnt stays 0 until m_ready rises, then becomes 1.
- s_last on the 3rd beat → frame_err pulses once, feat_vec unchanged, no m_valid; a following well-formed sample of seven beats of 255 → feat_vec=0x3FFF and a normal result.
- 7th beat without s_last → frame_err pulse, sample discarded; the next beat is treated as feature 0.
- Threshold edges: beats 63,64,127,128,191,192,0 → codes 0,1,1,2,2,3,0 → feat_vec=0x0E94.
- rst asserted in EVAL and again during a 4-beat partial sample → all outputs return to reset values next cycle, and the following full sample completes correctly.
